// File: rtl/screen_buf_arbiter.sv
// sync_fifo: generic single-clock FIFO with registered pointers and occupancy count.
// Latency: an entry pushed in cycle N is visible on rd_dat from cycle N+1.
// Backpressure: pushes are refused while full, even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_vld & ~full;
    assign pop    = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// screen_buf_arbiter: shares the single-port screen RAM between VDU scan-out, CPU and clear fill.
// Latency: VDU and CPU read data one cycle after grant; CPU writes reach RAM at least one cycle after accept.
// Backpressure: VDU is never stalled; cpu_wr_ready falls when the write FIFO is full; cpu_rd_ready waits for a quiet, drained port.
module screen_buf_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLEAR_WORDS = 4800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vdu_rden,
    input  logic [ADDR_W-1:0] vdu_addr,
    output logic [DATA_W-1:0] vdu_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_rd_valid,
    output logic              cpu_rd_ready,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_data_valid,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_char,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic {IDLE, CLEAR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0] clr_char_q, clr_char_nxt;

    wr_ent_t fifo_in;
    wr_ent_t fifo_out;
    logic    fifo_full;
    logic    fifo_empty;

    logic grant_vdu, grant_clr, grant_fifo, grant_rd;
    logic rd_vld_q;
    logic [DATA_W-1:0] rd_hold;

    assign fifo_in      = '{addr: cpu_wr_addr, data: cpu_wr_data};
    assign cpu_wr_ready = ~fifo_full;
    assign clr_busy     = (state == CLEAR);
    assign vdu_data     = ram_rdata;

    sync_fifo #(
        .WIDTH ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (cpu_wr_valid),
        .wr_dat (fifo_in),
        .rd_rdy (grant_fifo),
        .rd_dat (fifo_out),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Reads wait for an empty FIFO and no write in flight so they always see prior writes.
    always_comb begin
        grant_vdu    = vdu_rden;
        grant_clr    = 1'b0;
        grant_fifo   = 1'b0;
        grant_rd     = 1'b0;
        cpu_rd_ready = 1'b0;
        if (!vdu_rden) begin
            if (state == CLEAR) begin
                grant_clr = 1'b1;
            end else if (!fifo_empty) begin
                grant_fifo = 1'b1;
            end else if (!cpu_wr_valid && !rst) begin
                cpu_rd_ready = 1'b1;
                grant_rd     = cpu_rd_valid;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_rden  = 1'b0;
        if (grant_vdu) begin
            ram_addr = vdu_addr;
            ram_rden = 1'b1;
        end else if (grant_clr) begin
            ram_addr  = clr_cnt;
            ram_wdata = clr_char_q;
            ram_we    = 1'b1;
        end else if (grant_fifo) begin
            ram_addr  = fifo_out.addr;
            ram_wdata = fifo_out.data;
            ram_we    = 1'b1;
        end else if (grant_rd) begin
            ram_addr = cpu_rd_addr;
            ram_rden = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        clr_char_nxt = clr_char_q;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt    = CLEAR;
                    clr_cnt_nxt  = '0;
                    clr_char_nxt = clr_char;
                end
            end
            CLEAR: begin
                if (grant_clr) begin
                    if (clr_cnt == ADDR_W'(CLEAR_WORDS - 1)) state_nxt = IDLE;
                    else                                      clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_char_q <= '0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            clr_char_q <= clr_char_nxt;
        end
    end

    // The RAM output register supplies the read word in the valid cycle; rd_hold keeps it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_vld_q <= grant_rd;
            if (rd_vld_q) rd_hold <= ram_rdata;
        end
    end

    assign cpu_rd_data_valid = rd_vld_q;
    assign cpu_rd_data       = rd_vld_q ? ram_rdata : rd_hold;
endmodule

// File: tb/tb_screen_buf_arbiter.sv
// Bench for screen_buf_arbiter: BRAM model plus a reference memory updated from accepted writes and clears.
module tb_screen_buf_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        vdu_rden;
    logic [13:0] vdu_addr;
    logic [7:0]  vdu_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [13:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rd_valid;
    logic        cpu_rd_ready;
    logic [13:0] cpu_rd_addr;
    logic [7:0]  cpu_rd_data;
    logic        cpu_rd_data_valid;
    logic        clr_start;
    logic [7:0]  clr_char;
    logic        clr_busy;
    logic [13:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_rden;
    logic [7:0]  ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem     [0:16383];
    logic [7:0] ref_mem [0:16383];
    logic       mem_init_done = 1'b0;

    always #5 clk = ~clk;

    screen_buf_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .vdu_rden          (vdu_rden),
        .vdu_addr          (vdu_addr),
        .vdu_data          (vdu_data),
        .cpu_wr_valid      (cpu_wr_valid),
        .cpu_wr_ready      (cpu_wr_ready),
        .cpu_wr_addr       (cpu_wr_addr),
        .cpu_wr_data       (cpu_wr_data),
        .cpu_rd_valid      (cpu_rd_valid),
        .cpu_rd_ready      (cpu_rd_ready),
        .cpu_rd_addr       (cpu_rd_addr),
        .cpu_rd_data       (cpu_rd_data),
        .cpu_rd_data_valid (cpu_rd_data_valid),
        .clr_start         (clr_start),
        .clr_char          (clr_char),
        .clr_busy          (clr_busy),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_we            (ram_we),
        .ram_rden          (ram_rden),
        .ram_rdata         (ram_rdata)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    // Single-port BRAM with 1-cycle read latency, preloaded on the first clock.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
            mem_init_done <= 1'b1;
        end else begin
            if (ram_we)   mem[ram_addr] <= ram_wdata;
            if (ram_rden) ram_rdata     <= mem[ram_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        vdu_rden     = 1'b0;
        cpu_wr_valid = 1'b0;
        cpu_rd_valid = 1'b0;
        clr_start    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        vdu_addr = '0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_rd_addr = '0; clr_char = '0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0 || cpu_wr_ready !== 1'b1 || cpu_rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b wr_rdy=%b rd_rdy=%b, required 0 1 0", clr_busy, cpu_wr_ready, cpu_rd_ready);
        end
        checks++;
        if (cpu_rd_data !== 8'h00 || cpu_rd_data_valid !== 1'b0 || ram_we !== 1'b0 || ram_rden !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_data=%h rd_vld=%b we=%b rden=%b, required 00 0 0 0",
                     cpu_rd_data, cpu_rd_data_valid, ram_we, ram_rden);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rd_ready !== 1'b1 || cpu_wr_ready !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rd_rdy=%b wr_rdy=%b we=%b, required 1 1 0", cpu_rd_ready, cpu_wr_ready, ram_we);
        end
        tick();
    endtask

    task automatic test_vdu_only;
        for (int a = 0; a < 80; a++) begin
            vdu_rden = 1'b1;
            vdu_addr = 14'(a);
            @(negedge clk);
            checks++;
            if (ram_addr !== 14'(a) || ram_rden !== 1'b1 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL vdu_port a=%0d: addr=%h rden=%b we=%b, required addr=%h rden=1 we=0", a, ram_addr, ram_rden, ram_we, 14'(a));
            end
            if (a > 0) begin
                checks++;
                if (vdu_data !== ref_mem[a-1]) begin
                    errors++;
                    $display("FAIL vdu_data a=%0d: got %h, required %h", a - 1, vdu_data, ref_mem[a-1]);
                end
            end
            tick();
        end
        vdu_rden = 1'b0;
        @(negedge clk);
        checks++;
        if (vdu_data !== ref_mem[79]) begin
            errors++;
            $display("FAIL vdu_data_last: got %h, required %h", vdu_data, ref_mem[79]);
        end
        tick();
    endtask

    task automatic test_wr_under_vdu;
        int  nacc = 0;
        logic exp_rdy;
        vdu_rden = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vdu_addr     = 14'($urandom_range(0, 4095));
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 14'(16 + nacc);
            cpu_wr_data  = 8'(65 + nacc);
            @(negedge clk);
            exp_rdy = (nacc < 4);
            checks++;
            if (cpu_wr_ready !== exp_rdy || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL wr_fill c=%0d: wr_rdy=%b we=%b, required wr_rdy=%b we=0", c, cpu_wr_ready, ram_we, exp_rdy);
            end
            if (cpu_wr_ready) begin
                ref_mem[16 + nacc] = 8'(65 + nacc);
                nacc++;
            end
            tick();
        end
        vdu_rden = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cpu_wr_valid = (nacc < 5);
            cpu_wr_addr  = 14'(16 + nacc);
            cpu_wr_data  = 8'(65 + nacc);
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 14'(16 + k) || ram_wdata !== 8'(65 + k)) begin
                    errors++;
                    $display("FAIL drain k=%0d: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                             k, ram_we, ram_addr, ram_wdata, 14'(16 + k), 8'(65 + k));
                end
            end else begin
                checks++;
                if (ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_done: we=%b, required 0", ram_we);
                end
            end
            if (k < 2) begin
                checks++;
                if (cpu_wr_ready !== (k == 1)) begin
                    errors++;
                    $display("FAIL wr_ready_drain k=%0d: got %b, required %b", k, cpu_wr_ready, (k == 1));
                end
            end
            if (cpu_wr_valid && cpu_wr_ready) begin
                ref_mem[16 + nacc] = 8'(65 + nacc);
                nacc++;
            end
            tick();
        end
        cpu_wr_valid = 1'b0;
        for (int a = 16; a < 21; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a] || mem[a] !== 8'(65 + a - 16)) begin
                errors++;
                $display("FAIL wr_ram addr=%h: got %h, required %h", 14'(a), mem[a], 8'(65 + a - 16));
            end
        end
    endtask

    task automatic test_read_after_write;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0100; cpu_wr_data = 8'h5A;
        cpu_rd_valid = 1'b1; cpu_rd_addr = 14'h0100;
        @(negedge clk);
        checks++;
        if (cpu_wr_ready !== 1'b1 || cpu_rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_c0: wr_rdy=%b rd_rdy=%b, required 1 0", cpu_wr_ready, cpu_rd_ready);
        end
        ref_mem[14'h0100] = 8'h5A;
        tick();
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rd_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 14'h0100) begin
            errors++;
            $display("FAIL raw_c1: rd_rdy=%b we=%b addr=%h, required 0 1 0100", cpu_rd_ready, ram_we, ram_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rd_ready !== 1'b1 || ram_rden !== 1'b1 || ram_addr !== 14'h0100) begin
            errors++;
            $display("FAIL raw_c2: rd_rdy=%b rden=%b addr=%h, required 1 1 0100", cpu_rd_ready, ram_rden, ram_addr);
        end
        tick();
        cpu_rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rd_data_valid !== 1'b1 || cpu_rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL raw_data: vld=%b data=%h, required 1 5a", cpu_rd_data_valid, cpu_rd_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rd_data_valid !== 1'b0 || cpu_rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL raw_pulse: vld=%b data=%h, required 0 5a", cpu_rd_data_valid, cpu_rd_data);
        end
        tick();
    endtask

    task automatic test_clear;
        int busy = 0, wr_seen = 0, bad_wr = 0, bad_mem = 0, c = 0;
        clr_char = 8'h20; clr_start = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_busy_start: got %b, required 0", clr_busy);
        end
        tick();
        clr_start = 1'b0; clr_char = 8'h55;
        while (c < 8000) begin
            vdu_rden  = (c >= 100 && c < 740);
            vdu_addr  = 14'(c % 4096);
            clr_start = (c == 2000);
            @(negedge clk);
            if (!clr_busy) break;
            busy++;
            if (ram_we) begin
                if (ram_addr !== 14'(wr_seen) || ram_wdata !== 8'h20) bad_wr++;
                wr_seen++;
            end
            tick();
            c++;
        end
        idle_inputs();
        tick();
        checks++;
        if (busy != 4800 + 640) begin
            errors++;
            $display("FAIL clr_duration: busy %0d cycles, required %0d", busy, 4800 + 640);
        end
        checks++;
        if (wr_seen != 4800 || bad_wr != 0) begin
            errors++;
            $display("FAIL clr_writes: %0d writes with %0d bad, required 4800 with 0 bad", wr_seen, bad_wr);
        end
        for (int a = 0; a < 4800; a++) begin
            ref_mem[a] = 8'h20;
            if (mem[a] !== 8'h20) bad_mem++;
        end
        checks++;
        if (bad_mem != 0) begin
            errors++;
            $display("FAIL clr_contents: %0d words differ, required 0", bad_mem);
        end
        checks++;
        if (mem[4800] !== ref_mem[4800]) begin
            errors++;
            $display("FAIL clr_bound: word 4800 = %h, required %h", mem[4800], ref_mem[4800]);
        end
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL clr_restart_ignored: busy=%b we=%b, required 0 0", clr_busy, ram_we);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear;
        int nwr = 0, c = 0, late_wr = 0;
        clr_char = 8'h33; clr_start = 1'b1;
        @(negedge clk);
        tick();
        clr_start = 1'b0;
        while (nwr < 1000 && c < 3000) begin
            cpu_wr_valid = (c < 2);
            cpu_wr_addr  = 14'(8000 + c);
            cpu_wr_data  = 8'hEE;
            @(negedge clk);
            if (ram_we) nwr++;
            tick();
            c++;
        end
        cpu_wr_valid = 1'b0;
        checks++;
        if (nwr != 1000) begin
            errors++;
            $display("FAIL rmc_progress: %0d clear writes, required 1000", nwr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || ram_we !== 1'b0 || cpu_rd_ready !== 1'b0 || cpu_rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmc_reset: busy=%b we=%b rd_rdy=%b rd_vld=%b, required 0 0 0 0",
                     clr_busy, ram_we, cpu_rd_ready, cpu_rd_data_valid);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rd_ready !== 1'b1 || cpu_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmc_fifo_empty: rd_rdy=%b wr_rdy=%b, required 1 1", cpu_rd_ready, cpu_wr_ready);
        end
        tick();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_we) late_wr++;
            tick();
        end
        checks++;
        if (late_wr != 0) begin
            errors++;
            $display("FAIL rmc_no_writes: %0d writes after reset, required 0", late_wr);
        end
        for (int a = 0; a < 1000; a++) ref_mem[a] = 8'h33;
        checks++;
        if (mem[999] !== ref_mem[999] || mem[1000] !== ref_mem[1000] ||
            mem[8000] !== ref_mem[8000] || mem[8001] !== ref_mem[8001]) begin
            errors++;
            $display("FAIL rmc_contents: [999]=%h [1000]=%h [8000]=%h [8001]=%h, required %h %h %h %h",
                     mem[999], mem[1000], mem[8000], mem[8001], ref_mem[999], ref_mem[1000], ref_mem[8000], ref_mem[8001]);
        end
    endtask

    task automatic test_random;
        logic       pend = 1'b0;
        logic [7:0] pend_exp = 8'h00;
        int         bad_mem = 0;
        for (int c = 0; c < 1500; c++) begin
            vdu_rden     = ($urandom_range(0, 9) < 3);
            vdu_addr     = 14'($urandom_range(0, 255));
            cpu_wr_valid = ($urandom_range(0, 3) == 0);
            cpu_wr_addr  = 14'($urandom_range(0, 255));
            cpu_wr_data  = 8'($urandom);
            cpu_rd_valid = ($urandom_range(0, 1) == 1);
            cpu_rd_addr  = 14'($urandom_range(0, 255));
            @(negedge clk);
            checks++;
            if (cpu_rd_data_valid !== pend || (pend && cpu_rd_data !== pend_exp)) begin
                errors++;
                $display("FAIL rnd_read c=%0d: vld=%b data=%h, required vld=%b data=%h", c, cpu_rd_data_valid, cpu_rd_data, pend, pend_exp);
            end
            if (vdu_rden) begin
                checks++;
                if (ram_addr !== vdu_addr || ram_rden !== 1'b1 || ram_we !== 1'b0 || cpu_rd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_vdu c=%0d: addr=%h rden=%b we=%b rd_rdy=%b, required addr=%h 1 0 0",
                             c, ram_addr, ram_rden, ram_we, cpu_rd_ready, vdu_addr);
                end
            end
            pend = cpu_rd_valid && cpu_rd_ready;
            if (pend) pend_exp = ref_mem[cpu_rd_addr];
            if (cpu_wr_valid && cpu_wr_ready) ref_mem[cpu_wr_addr] = cpu_wr_data;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (cpu_rd_data_valid !== pend || (pend && cpu_rd_data !== pend_exp)) begin
            errors++;
            $display("FAIL rnd_read_last: vld=%b data=%h, required vld=%b data=%h", cpu_rd_data_valid, cpu_rd_data, pend, pend_exp);
        end
        tick();
        repeat (8) tick();
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad_mem++;
        checks++;
        if (bad_mem != 0) begin
            errors++;
            $display("FAIL rnd_contents: %0d words differ from reference, required 0", bad_mem);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i);
        test_reset();
        test_vdu_only();
        test_wr_under_vdu();
        test_read_after_write();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/screen_buf_arbiter.md
# screen_buf_arbiter

Shares the single-port character screen buffer RAM between three requesters: the VDU scan-out read port, a CPU write/read port, and an internal clear-screen fill engine. VDU reads have absolute priority and keep a fixed 1-cycle RAM latency, so the pixel pipeline timing is unchanged. CPU writes go through a small FIFO that drains in blanking or idle cycles. The block sits between the VDU, the CPU bus bridge and the screen buffer BRAM.

## Interface
- ADDR_W, 14, screen buffer address width
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, ≥2)
- CLEAR_WORDS, 4800, words written by a clear (80×60 characters)

- clk  in  1  pixel-domain clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vdu_rden  in  1  VDU read request (its is_drawing)
- vdu_addr  in  ADDR_W  VDU read address
- vdu_data  out  DATA_W  RAM read data, passed through combinationally from ram_rdata
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  FIFO not full
- cpu_wr_addr  in  ADDR_W  write address
- cpu_wr_data  in  DATA_W  write data
- cpu_rd_valid  in  1  CPU read request
- cpu_rd_ready  out  1  CPU read accepted this cycle
- cpu_rd_addr  in  ADDR_W  read address
- cpu_rd_data  out  DATA_W  registered read result
- cpu_rd_data_valid  out  1  one-cycle pulse, cpu_rd_data valid
- clr_start  in  1  start a clear-screen fill
- clr_char  in  DATA_W  fill character, sampled on the accepted clr_start
- clr_busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rden  out  1  RAM read enable
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency

## Operation
- Per-cycle grant, combinational, in fixed priority order:
  1. VDU, when vdu_rden = 1.
  2. Clear engine, when in state CLEAR.
  3. FIFO drain, when the FIFO is not empty.
  4. CPU read.
- The RAM port carries only the granted requester. When nothing is granted: ram_we = 0, ram_rden = 0, ram_addr = 0.
- cpu_wr_ready = !fifo_full. A push occurs on cpu_wr_valid & cpu_wr_ready. The FIFO keeps accepting writes while a clear is in progress.
- Push and pop in the same cycle: the count is unchanged. When full, the push is refused even if a pop occurs that cycle.
- cpu_rd_ready = !vdu_rden & state==IDLE & fifo_empty & !cpu_wr_valid. This gives read-after-write coherence. A read is issued on cpu_rd_valid & cpu_rd_ready.
- FSM states:
  - IDLE → CLEAR on clr_start. This latches clr_char and loads clr_cnt = 0.
  - In CLEAR, each granted cycle writes clr_char at address clr_cnt, then clr_cnt increments.
  - CLEAR → IDLE after writing address CLEAR_WORDS-1.
  - clr_start is ignored while in CLEAR.
- clr_busy = (state == CLEAR).
- clr_cnt is ADDR_W bits wide and never wraps; CLEAR_WORDS must be ≤ 2^ADDR_W.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- VDU: ram_addr = vdu_addr in the same cycle as vdu_rden; data appears on vdu_data the next cycle.
- CPU read: issued in cycle N; cpu_rd_data and cpu_rd_data_valid are registered and appear in cycle N+1.
- CPU write: accepted in cycle N; it reaches RAM at the earliest in cycle N+1 (FIFO registered), later if VDU or clear hold the port.
- Clear: clr_busy rises the cycle after the accepted clr_start. It takes exactly CLEAR_WORDS + (number of vdu_rden cycles during the clear) cycles, then falls the cycle after the last write.
- Reset values:
  - state = IDLE, clr_busy = 0, FIFO empty.
  - cpu_wr_ready = 1, cpu_rd_ready = 0 while rst is asserted, cpu_rd_data = 0, cpu_rd_data_valid = 0.
  - ram_we = 0, ram_rden = 0.
- Reset mid-clear or with the FIFO occupied: the clear is aborted, FIFO contents are discarded, and no pending cpu_rd_data_valid is produced.
- The VDU is never stalled; vdu_rden held high for the whole active line starves all other requesters without loss.

## Test plan
- Reset then idle: all outputs at reset values, cpu_wr_ready = 1.
- VDU only: vdu_rden = 1 with addresses 0..79 → ram_addr follows each cycle; vdu_data matches the RAM model one cycle later; ram_we never asserts.
- CPU writes under VDU load:
  - Stimulus: 5 back-to-back writes (addr 0x10..0x14, data 0x41..0x45) while vdu_rden = 1.
  - Response: cpu_wr_ready drops after 4 accepted writes.
  - After vdu_rden falls: 4 writes drain on consecutive cycles, the 5th is accepted, and the RAM model holds 0x41..0x45.
- Read-after-write:
  - Stimulus: write 0x5A to 0x0100, then immediately read 0x0100.
  - Response: cpu_rd_ready is held until the FIFO is empty; cpu_rd_data = 0x5A with cpu_rd_data_valid for 1 cycle.
- Clear with interruption:
  - Stimulus: clr_start with clr_char = 0x20; vdu_rden = 1 for 640 cycles during the clear.
  - Response: clr_busy lasts 4800 + 640 cycles; all 4800 words = 0x20; word 4800 untouched; a second clr_start mid-clear is ignored.
- Reset mid-clear:
  - Stimulus: assert rst after 1000 clear writes with 2 entries queued in the FIFO.
  - Response: clr_busy = 0 and the FIFO is empty immediately; no further RAM writes occur.
